// File: rtl/dma_pkg.sv
// Shared definitions for the single-channel DMA word controller:
// widths, direction constants and FSM state encoding.
package dma_pkg;

  localparam int WORD_W = 16;
  localparam int ADDR_W = 15;

  localparam logic DMA_RD = 1'b1;
  localparam logic DMA_WR = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DEV,
    MEM_ACC,
    RD_DATA,
    WR_RESP,
    ACK,
    GAP,
    DONE
  } dma_state_e;

endpackage

// File: rtl/dma_addr_cnt.sv
// Memory word address register and remaining-word counter for one transfer.
// The address wraps silently at the top of the 15-bit word space.
module dma_addr_cnt
  import dma_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_step,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [WORD_W-1:0] i_count,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last,
  output logic              o_zero
);

  logic [ADDR_W-1:0] r_addr;
  logic [WORD_W-1:0] r_count;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_addr  <= '0;
      r_count <= '0;
    end else if (i_load) begin
      r_addr  <= i_addr;
      r_count <= i_count;
    end else if (i_step) begin
      r_addr  <= r_addr + 1'b1;
      r_count <= r_count - 1'b1;
    end
  end

  assign o_addr = r_addr;
  assign o_last = (r_count == WORD_W'(1));
  assign o_zero = (r_count == '0);

endmodule

// File: rtl/dma_word_controller.sv
// Single-device DMA engine: moves 16-bit words between a peripheral and
// memory over the openMSP430 DMA master port, paced by the device's dev_ack.
module dma_word_controller
  import dma_pkg::*;
#(
  parameter logic PRIORITY    = 1'b0,
  parameter int   GAP_CYCLES  = 1,
  parameter int   ACK_TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dma_rqst,
  input  logic              dma_rd_wr,
  input  logic [WORD_W-1:0] dma_start_address,
  input  logic [WORD_W-1:0] dma_num_words,
  input  logic              dev_ack,
  input  logic [WORD_W-1:0] dev_data_in,
  output logic [WORD_W-1:0] dev_data_out,
  output logic              dma_ack,
  output logic              dma_end_flag,
  output logic              dma_error,
  output logic [ADDR_W-1:0] dma_addr,
  output logic [WORD_W-1:0] dma_din,
  output logic              dma_en,
  output logic [1:0]        dma_we,
  output logic              dma_priority,
  input  logic [WORD_W-1:0] dma_dout,
  input  logic              dma_ready,
  input  logic              dma_resp
);

  dma_state_e        r_state;
  dma_state_e        w_next;
  logic              r_dir;
  logic              r_err;
  logic [WORD_W-1:0] r_cnt;
  logic [WORD_W-1:0] r_din;
  logic [WORD_W-1:0] r_dout;

  logic              w_load;
  logic              w_step;
  logic              w_set_err;
  logic              w_cap_din;
  logic              w_cap_dout;
  logic              w_last;
  logic              w_zero;
  logic [ADDR_W-1:0] w_addr;
  logic              w_unused;

  // Byte address bit 0 carries no information for word transfers.
  assign w_unused = dma_start_address[0];

  dma_addr_cnt u_addr_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load),
    .i_step  (w_step),
    .i_addr  (dma_start_address[WORD_W-1:1]),
    .i_count (dma_num_words),
    .o_addr  (w_addr),
    .o_last  (w_last),
    .o_zero  (w_zero)
  );

  // NOTE: every signal gets a default before the case so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_step     = 1'b0;
    w_set_err  = 1'b0;
    w_cap_din  = 1'b0;
    w_cap_dout = 1'b0;
    unique case (r_state)
      IDLE: if (dma_rqst) begin
        w_load = 1'b1;
        w_next = (dma_num_words == '0) ? DONE : WAIT_DEV;
      end
      WAIT_DEV: begin
        // A request drop beats a simultaneous dev_ack.
        if (!dma_rqst) begin
          w_next = IDLE;
        end else if (dev_ack) begin
          w_cap_din = (r_dir == DMA_WR);
          w_next    = MEM_ACC;
        end else if (ACK_TIMEOUT != 0 && r_cnt == WORD_W'(ACK_TIMEOUT - 1)) begin
          w_set_err = 1'b1;
          w_next    = DONE;
        end
      end
      MEM_ACC: if (dma_ready) w_next = (r_dir == DMA_RD) ? RD_DATA : WR_RESP;
      RD_DATA: begin
        w_cap_dout = 1'b1;
        w_set_err  = dma_resp;
        w_next     = dma_resp ? DONE : ACK;
      end
      WR_RESP: begin
        w_set_err = dma_resp;
        w_next    = dma_resp ? DONE : ACK;
      end
      ACK: begin
        w_step = 1'b1;
        if (!dma_rqst)   w_next = IDLE;
        else if (w_last) w_next = DONE;
        else             w_next = GAP;
      end
      GAP: begin
        if (!dma_rqst)                                  w_next = IDLE;
        else if (r_cnt == WORD_W'(GAP_CYCLES - 1)) w_next = w_zero ? DONE : WAIT_DEV;
      end
      DONE: if (!dma_rqst) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_dir   <= DMA_WR;
      r_err   <= 1'b0;
      r_cnt   <= '0;
      r_din   <= '0;
      r_dout  <= '0;
    end else begin
      r_state <= w_next;
      // Shared cycle counter for the gap and the dev_ack timeout; restarts on
      // every state change.
      r_cnt   <= (w_next != r_state) ? '0 : r_cnt + 1'b1;
      if (w_load)          r_dir <= dma_rd_wr;
      if (w_set_err)       r_err <= 1'b1;
      else if (w_load)     r_err <= 1'b0;
      if (w_cap_din)       r_din <= dev_data_in;
      if (w_cap_dout)      r_dout <= dma_dout;
    end
  end

  assign dma_en       = (r_state == MEM_ACC);
  assign dma_we       = (r_state == MEM_ACC && r_dir == DMA_WR) ? 2'b11 : 2'b00;
  assign dma_ack      = (r_state == ACK);
  assign dma_end_flag = (r_state == DONE);
  assign dma_error    = (r_state == DONE) && r_err;
  assign dma_priority = PRIORITY;
  assign dma_addr     = w_addr;
  assign dma_din      = r_din;
  assign dev_data_out = r_dout;

endmodule

// File: tb/tb_dma_word_controller.sv
// Directed testbench for dma_word_controller with a small memory responder.
module tb_dma_word_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        dma_rqst = 1'b0;
  logic        dma_rd_wr = 1'b0;
  logic [15:0] dma_start_address = '0;
  logic [15:0] dma_num_words = '0;
  logic        dev_ack = 1'b0;
  logic [15:0] dev_data_in = '0;
  logic [15:0] dev_data_out;
  logic        dma_ack, dma_end_flag, dma_error, dma_en, dma_priority;
  logic [14:0] dma_addr;
  logic [15:0] dma_din;
  logic [1:0]  dma_we;
  logic [15:0] dma_dout = '0;
  logic        dma_ready = 1'b0;
  logic        dma_resp = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dma_word_controller #(.PRIORITY(1'b1), .GAP_CYCLES(2), .ACK_TIMEOUT(20)) dut (
    .clk(clk), .reset(reset), .dma_rqst(dma_rqst), .dma_rd_wr(dma_rd_wr),
    .dma_start_address(dma_start_address), .dma_num_words(dma_num_words),
    .dev_ack(dev_ack), .dev_data_in(dev_data_in), .dev_data_out(dev_data_out),
    .dma_ack(dma_ack), .dma_end_flag(dma_end_flag), .dma_error(dma_error),
    .dma_addr(dma_addr), .dma_din(dma_din), .dma_en(dma_en), .dma_we(dma_we),
    .dma_priority(dma_priority), .dma_dout(dma_dout), .dma_ready(dma_ready),
    .dma_resp(dma_resp)
  );

  // Memory responder: logs every granted access, returns read data next cycle.
  logic [15:0] mem [0:32767];
  logic        resp_err = 1'b0;
  logic [14:0] acc_addr [0:255];
  logic [1:0]  acc_we   [0:255];
  logic [15:0] acc_din  [0:255];
  int          acc_n = 0;

  always @(posedge clk) begin
    if (dma_en && dma_ready) begin
      acc_addr[acc_n[7:0]] = dma_addr;
      acc_we[acc_n[7:0]]   = dma_we;
      acc_din[acc_n[7:0]]  = dma_din;
      acc_n++;
      dma_dout <= mem[dma_addr];
      dma_resp <= resp_err;
    end else begin
      dma_resp <= 1'b0;
    end
  end

  // Output monitor sampled on the falling edge.
  logic [15:0] ack_data [0:255];
  int ack_cnt = 0, en_cycles = 0, overlap = 0;

  always @(negedge clk) begin
    if (dma_ack) begin
      ack_data[ack_cnt[7:0]] = dev_data_out;
      ack_cnt++;
    end
    if (dma_en) en_cycles++;
    if (dma_ack && dma_en) overlap++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    reset = 1'b0; dma_rqst = 1'b0; dev_ack = 1'b0; dma_ready = 1'b0; resp_err = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(1);
  endtask

  task automatic wait_end(input int max, output bit ok);
    int i = 0;
    while (!dma_end_flag && i < max) begin tick(1); i++; end
    ok = dma_end_flag;
  endtask

  task automatic wait_ack(input int max, output bit ok);
    int i = 0;
    while (!dma_ack && i < max) begin tick(1); i++; end
    ok = dma_ack;
  endtask

  task automatic wait_en(input int max, output bit ok);
    int i = 0;
    while (!dma_en && i < max) begin tick(1); i++; end
    ok = dma_en;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(2);
    n_checks++;
    if ({dma_ack, dma_end_flag, dma_error, dma_en, dma_we, dma_addr, dma_din, dev_data_out} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ack=%b end=%b err=%b en=%b we=%b addr=%h din=%h dout=%h, required all zero",
               dma_ack, dma_end_flag, dma_error, dma_en, dma_we, dma_addr, dma_din, dev_data_out);
    end
    n_checks++;
    if (dma_priority !== 1'b1) begin
      n_fail++; $display("FAIL reset_priority: got %b required 1", dma_priority);
    end
    reset = 1'b1;
    tick(1);
  endtask

  task automatic test_read();
    logic [15:0] exp_d [3];
    int a0, k0;
    bit ok;
    exp_d[0] = 16'hAAAA; exp_d[1] = 16'hBBBB; exp_d[2] = 16'hCCCC;
    reset_dut();
    a0 = acc_n; k0 = ack_cnt;
    mem[15'h100] = 16'hAAAA; mem[15'h101] = 16'hBBBB; mem[15'h102] = 16'hCCCC;
    dma_ready = 1'b1; dev_ack = 1'b1;
    dma_rd_wr = 1'b1; dma_start_address = 16'h0200; dma_num_words = 16'd3; dma_rqst = 1'b1;
    tick(1);
    // Changing request inputs mid-transfer must have no effect.
    dma_start_address = 16'h7000; dma_num_words = 16'd1; dma_rd_wr = 1'b0;
    wait_end(100, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL read_end: end flag not seen within 100 cycles"); end
    n_checks++;
    if (acc_n - a0 != 3) begin n_fail++; $display("FAIL read_acc_count: got %0d required 3", acc_n - a0); end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (acc_addr[a0 + i] !== 15'h100 + 15'(i) || acc_we[a0 + i] !== 2'b00) begin
        n_fail++;
        $display("FAIL read_access[%0d]: got addr=%h we=%b required addr=%h we=00",
                 i, acc_addr[a0 + i], acc_we[a0 + i], 15'h100 + 15'(i));
      end
    end
    n_checks++;
    if (ack_cnt - k0 != 3) begin n_fail++; $display("FAIL read_ack_count: got %0d required 3", ack_cnt - k0); end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (ack_data[k0 + i] !== exp_d[i]) begin
        n_fail++; $display("FAIL read_data[%0d]: got %h required %h", i, ack_data[k0 + i], exp_d[i]);
      end
    end
    n_checks++;
    if (dma_error !== 1'b0) begin n_fail++; $display("FAIL read_error: got %b required 0", dma_error); end
    tick(3);
    n_checks++;
    if (dma_end_flag !== 1'b1) begin n_fail++; $display("FAIL read_end_hold: got %b required 1", dma_end_flag); end
    dma_rqst = 1'b0;
    tick(1);
    n_checks++;
    if (dma_end_flag !== 1'b0) begin n_fail++; $display("FAIL read_end_clear: got %b required 0", dma_end_flag); end
    n_checks++;
    if (dev_data_out !== 16'hCCCC) begin n_fail++; $display("FAIL read_dout_hold: got %h required cccc", dev_data_out); end
  endtask

  task automatic test_write();
    int a0, e0;
    bit ok;
    reset_dut();
    a0 = acc_n;
    dma_ready = 1'b1; dev_data_in = 16'h1234; dev_ack = 1'b1;
    dma_rd_wr = 1'b0; dma_start_address = 16'h0300; dma_num_words = 16'd2; dma_rqst = 1'b1;
    wait_ack(50, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL write_first_ack: no dma_ack within 50 cycles"); end
    dev_ack = 1'b0; dev_data_in = 16'h5678;
    e0 = en_cycles;
    tick(5);
    n_checks++;
    if (en_cycles - e0 != 0) begin n_fail++; $display("FAIL write_idle_gap: got %0d dma_en cycles required 0", en_cycles - e0); end
    dev_ack = 1'b1;
    wait_end(50, ok);
    n_checks++;
    if (!ok || dma_error !== 1'b0) begin n_fail++; $display("FAIL write_end: got end=%b err=%b required end=1 err=0", dma_end_flag, dma_error); end
    n_checks++;
    if (acc_n - a0 != 2) begin n_fail++; $display("FAIL write_acc_count: got %0d required 2", acc_n - a0); end
    n_checks++;
    if (acc_addr[a0] !== 15'h180 || acc_we[a0] !== 2'b11 || acc_din[a0] !== 16'h1234) begin
      n_fail++; $display("FAIL write_word0: got addr=%h we=%b din=%h required 180/11/1234", acc_addr[a0], acc_we[a0], acc_din[a0]);
    end
    n_checks++;
    if (acc_addr[a0 + 1] !== 15'h181 || acc_we[a0 + 1] !== 2'b11 || acc_din[a0 + 1] !== 16'h5678) begin
      n_fail++; $display("FAIL write_word1: got addr=%h we=%b din=%h required 181/11/5678", acc_addr[a0 + 1], acc_we[a0 + 1], acc_din[a0 + 1]);
    end
    dma_rqst = 1'b0;
    tick(1);
  endtask

  task automatic test_zero_words();
    int e0;
    reset_dut();
    e0 = en_cycles;
    dma_ready = 1'b1; dev_ack = 1'b1; dma_rd_wr = 1'b1;
    dma_start_address = 16'h0500; dma_num_words = 16'd0; dma_rqst = 1'b1;
    tick(2);
    n_checks++;
    if (dma_end_flag !== 1'b1 || dma_error !== 1'b0) begin
      n_fail++; $display("FAIL zero_end: got end=%b err=%b required end=1 err=0", dma_end_flag, dma_error);
    end
    n_checks++;
    if (en_cycles - e0 != 0) begin n_fail++; $display("FAIL zero_no_access: got %0d dma_en cycles required 0", en_cycles - e0); end
    dma_rqst = 1'b0;
    tick(1);
    n_checks++;
    if (dma_end_flag !== 1'b0) begin n_fail++; $display("FAIL zero_clear: got %b required 0", dma_end_flag); end
  endtask

  task automatic test_stall_error();
    int a0, k0;
    bit ok, stable;
    reset_dut();
    a0 = acc_n; k0 = ack_cnt;
    dma_ready = 1'b0; dev_ack = 1'b1; dma_rd_wr = 1'b1;
    dma_start_address = 16'h0400; dma_num_words = 16'd2; dma_rqst = 1'b1;
    wait_en(20, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL stall_en: dma_en not seen within 20 cycles"); end
    stable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      if (dma_en !== 1'b1 || dma_addr !== 15'h200 || dma_we !== 2'b00) stable = 1'b0;
    end
    n_checks++;
    if (!stable) begin n_fail++; $display("FAIL stall_hold: got en=%b addr=%h we=%b required 1/200/00 throughout", dma_en, dma_addr, dma_we); end
    resp_err = 1'b1; dma_ready = 1'b1;
    wait_end(20, ok);
    n_checks++;
    if (!ok || dma_error !== 1'b1) begin n_fail++; $display("FAIL stall_error: got end=%b err=%b required 1/1", dma_end_flag, dma_error); end
    n_checks++;
    if (ack_cnt - k0 != 0 || acc_n - a0 != 1) begin
      n_fail++; $display("FAIL stall_counts: got acks=%0d accesses=%0d required 0/1", ack_cnt - k0, acc_n - a0);
    end
    resp_err = 1'b0; dma_rqst = 1'b0;
    tick(1);
    n_checks++;
    if (dma_end_flag !== 1'b0 || dma_error !== 1'b0) begin
      n_fail++; $display("FAIL stall_clear: got end=%b err=%b required 0/0", dma_end_flag, dma_error);
    end
  endtask

  task automatic test_wrap();
    int a0, k0;
    bit ok;
    reset_dut();
    a0 = acc_n; k0 = ack_cnt;
    mem[15'h7FFF] = 16'h1111; mem[15'h0000] = 16'h2222;
    dma_ready = 1'b1; dev_ack = 1'b1; dma_rd_wr = 1'b1;
    dma_start_address = 16'hFFFE; dma_num_words = 16'd2; dma_rqst = 1'b1;
    wait_end(60, ok);
    n_checks++;
    if (!ok || acc_n - a0 != 2) begin n_fail++; $display("FAIL wrap_end: got end=%b accesses=%0d required 1/2", dma_end_flag, acc_n - a0); end
    n_checks++;
    if (acc_addr[a0] !== 15'h7FFF || acc_addr[a0 + 1] !== 15'h0000) begin
      n_fail++; $display("FAIL wrap_addr: got %h,%h required 7fff,0000", acc_addr[a0], acc_addr[a0 + 1]);
    end
    n_checks++;
    if (ack_data[k0] !== 16'h1111 || ack_data[k0 + 1] !== 16'h2222) begin
      n_fail++; $display("FAIL wrap_data: got %h,%h required 1111,2222", ack_data[k0], ack_data[k0 + 1]);
    end
    dma_rqst = 1'b0;
    tick(1);
  endtask

  task automatic test_gap_abort();
    int a0, k0;
    bit ok;
    reset_dut();
    a0 = acc_n; k0 = ack_cnt;
    dma_ready = 1'b1; dev_ack = 1'b1; dma_rd_wr = 1'b1;
    dma_start_address = 16'h0600; dma_num_words = 16'd3; dma_rqst = 1'b1;
    wait_ack(30, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL gap_ack: no dma_ack within 30 cycles"); end
    tick(1);
    dma_rqst = 1'b0;
    tick(6);
    n_checks++;
    if (dma_end_flag !== 1'b0 || acc_n - a0 != 1 || ack_cnt - k0 != 1) begin
      n_fail++; $display("FAIL gap_abort: got end=%b accesses=%0d acks=%0d required 0/1/1", dma_end_flag, acc_n - a0, ack_cnt - k0);
    end
  endtask

  task automatic test_drop_wins();
    int e0;
    reset_dut();
    e0 = en_cycles;
    dma_ready = 1'b1; dev_ack = 1'b0; dma_rd_wr = 1'b1;
    dma_start_address = 16'h0700; dma_num_words = 16'd1; dma_rqst = 1'b1;
    tick(3);
    dev_ack = 1'b1; dma_rqst = 1'b0;
    tick(4);
    n_checks++;
    if (en_cycles - e0 != 0 || dma_end_flag !== 1'b0) begin
      n_fail++; $display("FAIL drop_wins: got en_cycles=%0d end=%b required 0/0", en_cycles - e0, dma_end_flag);
    end
  endtask

  task automatic test_timeout();
    int a0;
    bit ok;
    reset_dut();
    a0 = acc_n;
    dma_ready = 1'b1; dev_ack = 1'b0; dma_rd_wr = 1'b1;
    dma_start_address = 16'h0800; dma_num_words = 16'd1; dma_rqst = 1'b1;
    tick(10);
    n_checks++;
    if (dma_end_flag !== 1'b0) begin n_fail++; $display("FAIL timeout_early: got end=%b required 0", dma_end_flag); end
    wait_end(30, ok);
    n_checks++;
    if (!ok || dma_error !== 1'b1 || acc_n - a0 != 0) begin
      n_fail++; $display("FAIL timeout_error: got end=%b err=%b accesses=%0d required 1/1/0", dma_end_flag, dma_error, acc_n - a0);
    end
    dma_rqst = 1'b0;
    tick(1);
  endtask

  task automatic test_reset_mid();
    bit ok;
    reset_dut();
    mem[15'h480] = 16'h5A5A;
    dma_ready = 1'b0; dev_ack = 1'b1; dma_rd_wr = 1'b1;
    dma_start_address = 16'h0900; dma_num_words = 16'd4; dma_rqst = 1'b1;
    wait_en(20, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL reset_mid_en: dma_en not seen within 20 cycles"); end
    reset = 1'b0;
    tick(1);
    n_checks++;
    if (dma_en !== 1'b0) begin n_fail++; $display("FAIL reset_mid_drop: got dma_en=%b required 0", dma_en); end
    n_checks++;
    if ({dma_ack, dma_end_flag, dma_error, dma_we, dma_addr, dma_din, dev_data_out} !== '0 || dma_priority !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got ack=%b end=%b err=%b we=%b addr=%h din=%h dout=%h pri=%b required zeros, pri=1",
               dma_ack, dma_end_flag, dma_error, dma_we, dma_addr, dma_din, dev_data_out, dma_priority);
    end
    dma_rqst = 1'b0;
    reset = 1'b1;
    tick(1);
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_zero_words();
    test_stall_error();
    test_wrap();
    test_gap_abort();
    test_drop_wins();
    test_timeout();
    test_reset_mid();
    n_checks++;
    if (overlap != 0) begin n_fail++; $display("FAIL ack_en_overlap: got %0d cycles required 0", overlap); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
